// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue
//   Retire-side commit tracker. Up to COMMIT_W retired instructions per cycle
//   are pushed into a DEPTH-entry FIFO and drained in order onto COMMIT_W
//   registered commit lanes. Also keeps cycle/instruction counters, detects
//   the 0x6b trap instruction (freezing intake afterwards) and runs an idle
//   watchdog.
//
// Ports
//   clk, rst                        clock, async active-low reset
//   in_valid/pc/inst/wen/wdest/wdata retire group, lane 0 oldest
//   in_a0                           a0[7:0] seen by a retiring trap
//   in_ready                        whole group may be accepted (combinational)
//   drain_en                        pop permission
//   out_valid/pc/inst/wen/wdest/wdata registered commit lanes
//   trap_valid/trap_code/trap_pc    trap commit status (sticky)
//   cycle_cnt, instr_cnt            64-bit counters, frozen after trap commit
//   timeout, seq_err                sticky watchdog / lane-pattern flags
module difftest_commit_queue #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COMMIT_W-1:0]     in_valid,
    input  logic [64*COMMIT_W-1:0]  in_pc,
    input  logic [32*COMMIT_W-1:0]  in_inst,
    input  logic [COMMIT_W-1:0]     in_wen,
    input  logic [5*COMMIT_W-1:0]   in_wdest,
    input  logic [64*COMMIT_W-1:0]  in_wdata,
    input  logic [7:0]              in_a0,
    output logic                    in_ready,
    input  logic                    drain_en,
    output logic [COMMIT_W-1:0]     out_valid,
    output logic [64*COMMIT_W-1:0]  out_pc,
    output logic [32*COMMIT_W-1:0]  out_inst,
    output logic [COMMIT_W-1:0]     out_wen,
    output logic [8*COMMIT_W-1:0]   out_wdest,
    output logic [64*COMMIT_W-1:0]  out_wdata,
    output logic                    trap_valid,
    output logic [7:0]              trap_code,
    output logic [63:0]             trap_pc,
    output logic [63:0]             cycle_cnt,
    output logic [63:0]             instr_cnt,
    output logic                    timeout,
    output logic                    seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(COMMIT_W + 1);
    localparam logic [PW-1:0] READY_MAX  = PW'(DEPTH - COMMIT_W);
    localparam logic [CW-1:0] LANES      = CW'(COMMIT_W);
    localparam logic [31:0]   IDLE_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    logic [63:0] r_mem_pc    [DEPTH];
    logic [31:0] r_mem_inst  [DEPTH];
    logic        r_mem_wen   [DEPTH];
    logic [4:0]  r_mem_wdest [DEPTH];
    logic [63:0] r_mem_wdata [DEPTH];
    logic        r_mem_trap  [DEPTH];

    logic [PW-1:0]           r_wr, r_rd;
    logic                    r_frozen;
    logic [31:0]             r_idle_cnt;
    logic [COMMIT_W-1:0]     r_out_valid;
    logic [64*COMMIT_W-1:0]  r_out_pc;
    logic [32*COMMIT_W-1:0]  r_out_inst;
    logic [COMMIT_W-1:0]     r_out_wen;
    logic [8*COMMIT_W-1:0]   r_out_wdest;
    logic [64*COMMIT_W-1:0]  r_out_wdata;
    logic                    r_trap_valid;
    logic [7:0]              r_trap_code;
    logic [63:0]             r_trap_pc;
    logic [63:0]             r_cycle_cnt, r_instr_cnt;
    logic                    r_timeout, r_seq_err;

    logic [PW-1:0] w_count;
    logic          w_ready, w_accept, w_stop, w_gap, w_trap_hit, w_trap_take;
    logic [CW-1:0] w_run, w_trap_lane, w_n_push, w_n_pop;

    assign w_count  = r_wr - r_rd;
    assign w_ready  = (w_count <= READY_MAX) && !r_frozen;
    assign w_accept = w_ready && (|in_valid);
    assign w_n_pop  = !drain_en ? '0 :
                      (w_count >= PW'(COMMIT_W)) ? LANES : w_count[CW-1:0];

    // Contiguous valid run from lane 0, any valid lane beyond a hole, and the
    // lowest trap inside the run. A trap truncates the run just above itself.
    always_comb begin
        w_run       = '0;
        w_stop      = 1'b0;
        w_gap       = 1'b0;
        w_trap_hit  = 1'b0;
        w_trap_lane = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (!in_valid[i]) begin
                w_stop = 1'b1;
            end else if (w_stop) begin
                w_gap = 1'b1;
            end else begin
                w_run = CW'(i + 1);
                if (!w_trap_hit && in_inst[32*i +: 7] == 7'h6b) begin
                    w_trap_hit  = 1'b1;
                    w_trap_lane = CW'(i);
                end
            end
        end
    end

    assign w_trap_take = w_accept && w_trap_hit;
    assign w_n_push    = !w_accept ? '0 :
                         w_trap_hit ? (w_trap_lane + 1'b1) : w_run;

    // FIFO storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (i < int'(w_n_push)) begin
                r_mem_pc   [r_wr[AW-1:0] + AW'(i)] <= in_pc[64*i +: 64];
                r_mem_inst [r_wr[AW-1:0] + AW'(i)] <= in_inst[32*i +: 32];
                r_mem_wen  [r_wr[AW-1:0] + AW'(i)] <= in_wen[i];
                r_mem_wdest[r_wr[AW-1:0] + AW'(i)] <= in_wdest[5*i +: 5];
                r_mem_wdata[r_wr[AW-1:0] + AW'(i)] <= in_wdata[64*i +: 64];
                r_mem_trap [r_wr[AW-1:0] + AW'(i)] <= w_trap_hit && (CW'(i) == w_trap_lane);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_frozen     <= 1'b0;
            r_idle_cnt   <= '0;
            r_out_valid  <= '0;
            r_out_pc     <= '0;
            r_out_inst   <= '0;
            r_out_wen    <= '0;
            r_out_wdest  <= '0;
            r_out_wdata  <= '0;
            r_trap_valid <= 1'b0;
            r_trap_code  <= '0;
            r_trap_pc    <= '0;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
            r_timeout    <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_wr <= r_wr + PW'(w_n_push);
            r_rd <= r_rd + PW'(w_n_pop);
            if (w_trap_take) begin
                r_frozen    <= 1'b1;
                r_trap_code <= in_a0;
            end
            if (w_accept && w_gap) begin
                r_seq_err <= 1'b1;
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (i < int'(w_n_pop)) begin
                    r_out_valid[i]          <= 1'b1;
                    r_out_pc[64*i +: 64]    <= r_mem_pc   [r_rd[AW-1:0] + AW'(i)];
                    r_out_inst[32*i +: 32]  <= r_mem_inst [r_rd[AW-1:0] + AW'(i)];
                    r_out_wen[i]            <= r_mem_wen  [r_rd[AW-1:0] + AW'(i)];
                    r_out_wdest[8*i +: 8]   <= {3'b0, r_mem_wdest[r_rd[AW-1:0] + AW'(i)]};
                    r_out_wdata[64*i +: 64] <= r_mem_wdata[r_rd[AW-1:0] + AW'(i)];
                    if (r_mem_trap[r_rd[AW-1:0] + AW'(i)]) begin
                        r_trap_valid <= 1'b1;
                        r_trap_pc    <= r_mem_pc[r_rd[AW-1:0] + AW'(i)];
                    end
                end else begin
                    r_out_valid[i] <= 1'b0;
                end
            end
            // Counters still advance on the trap-commit edge itself.
            if (!r_trap_valid) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
                r_instr_cnt <= r_instr_cnt + 64'(w_n_pop);
            end
            if (w_n_pop != '0) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end
            if (TIMEOUT != 0 && !r_trap_valid && w_n_pop == '0 && r_idle_cnt >= IDLE_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_inst   = r_out_inst;
    assign out_wen    = r_out_wen;
    assign out_wdest  = r_out_wdest;
    assign out_wdata  = r_out_wdata;
    assign trap_valid = r_trap_valid;
    assign trap_code  = r_trap_code;
    assign trap_pc    = r_trap_pc;
    assign cycle_cnt  = r_cycle_cnt;
    assign instr_cnt  = r_instr_cnt;
    assign timeout    = r_timeout;
    assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue (COMMIT_W=2, DEPTH=8, TIMEOUT=16).
module tb_difftest_commit_queue;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] TRAP = 32'h0000006b;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    in_valid;
    logic [127:0]  in_pc;
    logic [63:0]   in_inst;
    logic [1:0]    in_wen;
    logic [9:0]    in_wdest;
    logic [127:0]  in_wdata;
    logic [7:0]    in_a0;
    logic          in_ready;
    logic          drain_en;
    logic [1:0]    out_valid;
    logic [127:0]  out_pc;
    logic [63:0]   out_inst;
    logic [1:0]    out_wen;
    logic [15:0]   out_wdest;
    logic [127:0]  out_wdata;
    logic          trap_valid;
    logic [7:0]    trap_code;
    logic [63:0]   trap_pc;
    logic [63:0]   cycle_cnt;
    logic [63:0]   instr_cnt;
    logic          timeout;
    logic          seq_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    difftest_commit_queue #(.COMMIT_W(2), .DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
        .in_wdest(in_wdest), .in_wdata(in_wdata), .in_a0(in_a0), .in_ready(in_ready),
        .drain_en(drain_en),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen),
        .out_wdest(out_wdest), .out_wdata(out_wdata),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .timeout(timeout), .seq_err(seq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [63:0] pc, input logic [31:0] inst);
        in_pc[64*l +: 64]    = pc;
        in_inst[32*l +: 32]  = inst;
        in_wen[l]            = 1'b1;
        in_wdest[5*l +: 5]   = pc[6:2];
        in_wdata[64*l +: 64] = ~pc;
    endtask

    task automatic set_group(input logic [63:0] pc0, input logic [1:0] v);
        set_lane(0, pc0, ADDI);
        set_lane(1, pc0 + 64'd4, ADDI);
        in_valid = v;
    endtask

    task automatic chk_group(input string tag, input logic [63:0] pc0);
        logic [63:0] pc1;
        pc1 = pc0 + 64'd4;
        chk({tag, ".valid"}, out_valid, 2'b11);
        chk({tag, ".pc0"}, out_pc[63:0], pc0);
        chk({tag, ".pc1"}, out_pc[127:64], pc1);
        chk({tag, ".inst0"}, out_inst[31:0], ADDI);
        chk({tag, ".wen"}, out_wen, 2'b11);
        chk({tag, ".wdest1"}, out_wdest[15:8], {3'b0, pc1[6:2]});
        chk({tag, ".wdata0"}, out_wdata[63:0], ~pc0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = '0;
        in_pc    = '0;
        in_inst  = '0;
        in_wen   = '0;
        in_wdest = '0;
        in_wdata = '0;
        in_a0    = '0;
        drain_en = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 2'b00);
        chk("rst.cycle", cycle_cnt, 64'd0);
        chk("rst.instr", instr_cnt, 64'd0);
        chk("rst.timeout", timeout, 1'b0);
        chk("rst.trap_valid", trap_valid, 1'b0);
        chk("rst.seq_err", seq_err, 1'b0);
        rst      = 1'b1;
        drain_en = 1'b1;

        // watchdog: empty FIFO, nothing commits
        repeat (15) tick();
        chk("wd.timeout15", timeout, 1'b0);
        chk("wd.cycle15", cycle_cnt, 64'd15);
        tick();
        chk("wd.timeout16", timeout, 1'b1);
        repeat (4) tick();
        chk("wd.timeout20", timeout, 1'b1);
        chk("wd.cycle20", cycle_cnt, 64'd20);
        chk("wd.out_valid", out_valid, 2'b00);

        // asynchronous reset in the middle of a cycle
        #3;
        rst = 1'b0;
        #1;
        chk("arst.timeout", timeout, 1'b0);
        chk("arst.cycle", cycle_cnt, 64'd0);
        chk("arst.instr", instr_cnt, 64'd0);
        chk("arst.in_ready", in_ready, 1'b1);
        chk("arst.trap_valid", trap_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // basic flow: two lanes per cycle, one-cycle latency
        set_group(64'h80000000, 2'b11);
        tick();
        set_group(64'h80000008, 2'b11);
        tick();
        chk_group("basic.g0", 64'h80000000);
        set_group(64'h80000010, 2'b11);
        tick();
        chk_group("basic.g1", 64'h80000008);
        in_valid = 2'b00;
        tick();
        chk_group("basic.g2", 64'h80000010);
        chk("basic.instr", instr_cnt, 64'd6);
        tick();
        chk("basic.idle_valid", out_valid, 2'b00);
        chk("basic.hold_pc0", out_pc[63:0], 64'h80000010);

        // backpressure, drained across the pointer wrap
        drain_en = 1'b0;
        set_group(64'h90000000, 2'b11);
        chk("bp.ready0", in_ready, 1'b1);
        tick();
        set_group(64'h90000008, 2'b11);
        tick();
        set_group(64'h90000010, 2'b11);
        tick();
        chk("bp.ready6", in_ready, 1'b1);
        set_group(64'h90000018, 2'b11);
        tick();
        chk("bp.ready8", in_ready, 1'b0);
        set_group(64'h90000020, 2'b11);
        drain_en = 1'b1;
        #1;
        chk("bp.ready8_pop", in_ready, 1'b0);
        tick();
        chk_group("bp.g0", 64'h90000000);
        chk("bp.ready_after_pop", in_ready, 1'b1);
        tick();
        chk_group("bp.g1", 64'h90000008);
        in_valid = 2'b00;
        tick();
        chk_group("bp.g2", 64'h90000010);
        tick();
        chk_group("bp.g3", 64'h90000018);
        tick();
        chk_group("bp.g4", 64'h90000020);
        chk("bp.instr", instr_cnt, 64'd16);
        tick();
        chk("bp.empty_valid", out_valid, 2'b00);

        // trap in lane 1
        do_reset();
        in_a0 = 8'h00;
        set_lane(0, 64'hA0000000, ADDI);
        set_lane(1, 64'hA0000004, TRAP);
        in_valid = 2'b11;
        tick();
        chk("trap1.ready", in_ready, 1'b0);
        chk("trap1.tv_early", trap_valid, 1'b0);
        chk("trap1.valid_early", out_valid, 2'b00);
        set_group(64'hD0000000, 2'b11);
        tick();
        chk("trap1.tv", trap_valid, 1'b1);
        chk("trap1.pc", trap_pc, 64'hA0000004);
        chk("trap1.code", trap_code, 8'h00);
        chk("trap1.valid", out_valid, 2'b11);
        chk("trap1.out_pc1", out_pc[127:64], 64'hA0000004);
        chk("trap1.instr", instr_cnt, 64'd2);
        chk("trap1.cycle", cycle_cnt, 64'd2);
        repeat (3) tick();
        chk("trap1.cycle_frozen", cycle_cnt, 64'd2);
        chk("trap1.instr_frozen", instr_cnt, 64'd2);
        chk("trap1.valid_after", out_valid, 2'b00);
        chk("trap1.ready_after", in_ready, 1'b0);

        // trap in lane 0: lane 1 dropped without error
        do_reset();
        in_a0 = 8'h2A;
        set_lane(0, 64'hB0000000, TRAP);
        set_lane(1, 64'hB0000004, ADDI);
        in_valid = 2'b11;
        tick();
        in_valid = 2'b00;
        tick();
        chk("trap0.valid", out_valid, 2'b01);
        chk("trap0.tv", trap_valid, 1'b1);
        chk("trap0.pc", trap_pc, 64'hB0000000);
        chk("trap0.code", trap_code, 8'h2A);
        chk("trap0.seq_err", seq_err, 1'b0);
        chk("trap0.instr", instr_cnt, 64'd1);
        tick();
        chk("trap0.instr_frozen", instr_cnt, 64'd1);
        chk("trap0.valid_after", out_valid, 2'b00);

        // sequence error: lane 1 valid with lane 0 idle
        do_reset();
        in_a0 = 8'h00;
        set_group(64'hC0000000, 2'b10);
        tick();
        chk("seq.flag", seq_err, 1'b1);
        chk("seq.ready", in_ready, 1'b1);
        in_valid = 2'b00;
        tick();
        chk("seq.nothing", out_valid, 2'b00);
        chk("seq.instr", instr_cnt, 64'd0);
        set_group(64'hC0000010, 2'b11);
        tick();
        in_valid = 2'b00;
        tick();
        chk_group("seq.after", 64'hC0000010);
        chk("seq.sticky", seq_err, 1'b1);
        chk("seq.instr2", instr_cnt, 64'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
